// File: rtl/regbank_wr_arbiter.sv
// Round-robin arbiter that shares the register-bank write port between REQ_COUNT writeback sources.
// The winning write goes through one staging register, and a per-register pending mask is exported for hazard logic.
module regbank_wr_arbiter #(
    parameter  int REG_WIDTH = 32,
    parameter  int REG_COUNT = 16,
    parameter  int REQ_COUNT = 2,
    localparam int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 hold,
    input  logic [REQ_COUNT-1:0]                 req_valid,
    input  logic [REQ_COUNT-1:0][ADDR_W-1:0]     req_addr,
    input  logic [REQ_COUNT-1:0][REG_WIDTH-1:0]  req_data,
    output logic [REQ_COUNT-1:0]                 req_ready,
    output logic                                 we,
    output logic [ADDR_W-1:0]                    waddr,
    output logic [REG_WIDTH-1:0]                 wdata,
    output logic [REG_COUNT-1:0]                 pending
);

    localparam int PTR_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_found;
    logic [ADDR_W-1:0]    win_addr;
    logic [REG_WIDTH-1:0] win_data;
    int                   cand;

    // Scan ptr+1, ptr+2, ... (mod REQ_COUNT). The first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = 0;
        for (int k = 1; k <= REQ_COUNT; k++) begin
            cand = int'(ptr) + k;
            if (cand >= REQ_COUNT) begin
                cand = cand - REQ_COUNT;
            end
            if (!win_found && req_valid[PTR_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
        if (hold || !rst_n) begin
            win_found = 1'b0;
        end
    end

    // Only the granted requester's address/data are ever selected, so X on idle requesters stays out.
    always_comb begin
        req_ready = '0;
        win_addr  = '0;
        win_data  = '0;
        if (win_found) begin
            req_ready[win_idx] = 1'b1;
            win_addr           = req_addr[win_idx];
            win_data           = req_data[win_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= PTR_W'(REQ_COUNT - 1);
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= win_found;
            if (win_found) begin
                ptr   <= win_idx;
                waddr <= win_addr;
                wdata <= win_data;
            end
        end
    end

    // Decoded only from registered state, so the mask changes only on a clock edge or on reset.
    always_comb begin
        pending = '0;
        if (we) begin
            pending[waddr] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Self-checking bench for regbank_wr_arbiter: a table of directed vectors, hand-written reset/collision sequences,
// and randomized traffic checked against a behavioural round-robin model with a register-bank image.
module tb_regbank_wr_arbiter;

    localparam int NREQ = 2;
    localparam int NREG = 16;

    logic             clk;
    logic             rst_n;
    logic             hold;
    logic [1:0]       req_valid;
    logic [1:0][3:0]  req_addr;
    logic [1:0][31:0] req_data;
    logic [1:0]       req_ready;
    logic             we;
    logic [3:0]       waddr;
    logic [31:0]      wdata;
    logic [15:0]      pending;

    regbank_wr_arbiter #(
        .REG_WIDTH(32),
        .REG_COUNT(NREG),
        .REQ_COUNT(NREQ)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_ready(req_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The register bank this port feeds; it is not cleared by reset.
    logic [31:0] bank [NREG];
    always @(posedge clk) begin
        if (we) bank[waddr] <= wdata;
    end

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model state.
    int          m_ptr;
    logic        m_we;
    logic [3:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_bank [NREG];
    bit          m_written [NREG];
    logic [1:0]  exp_grant;

    // DUT samples taken by applyStimulus.
    logic [1:0]  seen_ready;
    logic        seen_we;
    logic [3:0]  seen_waddr;
    logic [31:0] seen_wdata;
    logic [15:0] seen_pending;

    typedef struct {
        logic        h;
        logic [1:0]  v;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  rdy;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [15:0] pend;
    } vec_t;

    vec_t vecs [13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // First valid requester in the order ptr+1, ptr+2, ... wins unless held.
    function automatic logic [1:0] modelGrant(input logic h, input logic [1:0] v, input int p);
        logic [1:0] g;
        g = '0;
        if (!h) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (p + k) % NREQ;
                if (((v >> c) & 2'b01) != 2'b00) begin
                    g = 2'(1 << c);
                    return g;
                end
            end
        end
        return g;
    endfunction

    task automatic modelReset();
        m_we  = 1'b0;
        m_ptr = NREQ - 1;
    endtask

    // At a clock edge the bank commits the staged write, then the stage is reloaded with the winner.
    task automatic modelCommit(input logic [1:0] g);
        if (m_we) begin
            m_bank[m_waddr]    = m_wdata;
            m_written[m_waddr] = 1'b1;
        end
        if (g != 2'b00) begin
            m_ptr   = g[1] ? 1 : 0;
            m_we    = 1'b1;
            m_waddr = g[1] ? req_addr[1] : req_addr[0];
            m_wdata = g[1] ? req_data[1] : req_data[0];
        end else begin
            m_we = 1'b0;
        end
    endtask

    // Drives one cycle of inputs at the falling edge and samples the DUT away from the rising edge.
    task automatic applyStimulus(input logic h, input logic [1:0] v, input logic [3:0] a0, input logic [3:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1);
        hold        = h;
        req_valid   = v;
        req_addr[0] = a0;
        req_addr[1] = a1;
        req_data[0] = d0;
        req_data[1] = d1;
        exp_grant   = modelGrant(h, v, m_ptr);
        #1;
        seen_ready = req_ready;
        @(posedge clk);
        modelCommit(exp_grant);
        #1;
        seen_we      = we;
        seen_waddr   = waddr;
        seen_wdata   = wdata;
        seen_pending = pending;
        @(negedge clk);
    endtask

    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, ".ready"}, 32'(seen_ready), 32'(exp_grant));
        checkOutput({tag, ".we"}, 32'(seen_we), 32'(m_we));
        checkOutput({tag, ".pending"}, 32'(seen_pending), m_we ? (32'h1 << m_waddr) : 32'h0);
        if (m_we) begin
            checkOutput({tag, ".waddr"}, 32'(seen_waddr), 32'(m_waddr));
            checkOutput({tag, ".wdata"}, seen_wdata, m_wdata);
        end
    endtask

    logic [1:0]  cur_v;
    logic [3:0]  cur_a [2];
    logic [31:0] cur_d [2];

    initial begin
        // Both requesters contend: grants 0,1,0,1; then a 3-cycle hold; then directed single-source writes.
        vecs[0]  = '{1'b0, 2'b11, 4'd1, 4'd2, 32'hA000_0000, 32'hB000_0000, 2'b01, 1'b1, 4'd1, 32'hA000_0000, 16'h0002};
        vecs[1]  = '{1'b0, 2'b11, 4'd1, 4'd2, 32'hA000_0001, 32'hB000_0000, 2'b10, 1'b1, 4'd2, 32'hB000_0000, 16'h0004};
        vecs[2]  = '{1'b0, 2'b11, 4'd1, 4'd2, 32'hA000_0001, 32'hB000_0001, 2'b01, 1'b1, 4'd1, 32'hA000_0001, 16'h0002};
        vecs[3]  = '{1'b0, 2'b11, 4'd1, 4'd2, 32'hA000_0002, 32'hB000_0001, 2'b10, 1'b1, 4'd2, 32'hB000_0001, 16'h0004};
        vecs[4]  = '{1'b1, 2'b11, 4'd1, 4'd2, 32'hA000_0002, 32'hB000_0002, 2'b00, 1'b0, 4'd0, 32'h0, 16'h0000};
        vecs[5]  = '{1'b1, 2'b11, 4'd1, 4'd2, 32'hA000_0002, 32'hB000_0002, 2'b00, 1'b0, 4'd0, 32'h0, 16'h0000};
        vecs[6]  = '{1'b1, 2'b11, 4'd1, 4'd2, 32'hA000_0002, 32'hB000_0002, 2'b00, 1'b0, 4'd0, 32'h0, 16'h0000};
        vecs[7]  = '{1'b0, 2'b11, 4'd1, 4'd2, 32'hA000_0002, 32'hB000_0002, 2'b01, 1'b1, 4'd1, 32'hA000_0002, 16'h0002};
        vecs[8]  = '{1'b0, 2'b10, 4'd0, 4'd5, 32'h0, 32'hDEAD_BEEF, 2'b10, 1'b1, 4'd5, 32'hDEAD_BEEF, 16'h0020};
        vecs[9]  = '{1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 2'b00, 1'b0, 4'd0, 32'h0, 16'h0000};
        vecs[10] = '{1'b0, 2'b01, 4'd9, 4'd0, 32'h0000_1234, 32'h0, 2'b01, 1'b1, 4'd9, 32'h0000_1234, 16'h0200};
        vecs[11] = '{1'b0, 2'b01, 4'd15, 4'd0, 32'h0000_0055, 32'h0, 2'b01, 1'b1, 4'd15, 32'h0000_0055, 16'h8000};
        vecs[12] = '{1'b0, 2'b10, 4'd0, 4'd0, 32'h0, 32'h0000_0077, 2'b10, 1'b1, 4'd0, 32'h0000_0077, 16'h0001};

        for (int r = 0; r < NREG; r++) m_written[r] = 1'b0;
        modelReset();
        exp_grant   = '0;
        rst_n       = 1'b0;
        hold        = 1'b0;
        req_valid   = 2'b11;
        req_addr[0] = 4'd1;
        req_addr[1] = 4'd2;
        req_data[0] = 32'h1;
        req_data[1] = 32'h2;

        // Reset with both requesters valid.
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset.ready", 32'(req_ready), 32'h0);
        checkOutput("reset.we", 32'(we), 32'h0);
        checkOutput("reset.pending", 32'(pending), 32'h0);
        checkOutput("reset.waddr", 32'(waddr), 32'h0);
        checkOutput("reset.wdata", wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].h, vecs[i].v, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            checkOutput($sformatf("vec%0d.ready", i), 32'(seen_ready), 32'(vecs[i].rdy));
            checkOutput($sformatf("vec%0d.we", i), 32'(seen_we), 32'(vecs[i].we));
            checkOutput($sformatf("vec%0d.pending", i), 32'(seen_pending), 32'(vecs[i].pend));
            if (vecs[i].we) begin
                checkOutput($sformatf("vec%0d.waddr", i), 32'(seen_waddr), 32'(vecs[i].wa));
                checkOutput($sformatf("vec%0d.wdata", i), seen_wdata, vecs[i].wd);
            end
        end

        // Reset arriving while a write to R7 is staged must drop it before the bank sees it.
        applyStimulus(1'b0, 2'b01, 4'd7, 4'd0, 32'hAAAA_0007, 32'h0);
        checkOutput("r7.first.we", 32'(seen_we), 32'h1);
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
        checkOutput("r7.first.bank", bank[7], 32'hAAAA_0007);
        hold        = 1'b0;
        req_valid   = 2'b01;
        req_addr[0] = 4'd7;
        req_data[0] = 32'hBBBB_0007;
        exp_grant   = modelGrant(1'b0, 2'b01, m_ptr);
        @(posedge clk);
        modelCommit(exp_grant);
        #3;
        checkOutput("r7.staged.we", 32'(we), 32'h1);
        checkOutput("r7.staged.pending", 32'(pending), 32'h0080);
        rst_n = 1'b0;
        #1;
        checkOutput("r7.async.we", 32'(we), 32'h0);
        checkOutput("r7.async.pending", 32'(pending), 32'h0);
        checkOutput("r7.async.ready", 32'(req_ready), 32'h0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("r7.kept", bank[7], 32'hAAAA_0007);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n     = 1'b1;

        // Same-address collision right after reset: req0 goes first, so req1's value survives.
        applyStimulus(1'b0, 2'b11, 4'd3, 4'd3, 32'h11, 32'h22);
        checkOutput("r3.first.ready", 32'(seen_ready), 32'h1);
        checkOutput("r3.first.wdata", seen_wdata, 32'h11);
        applyStimulus(1'b0, 2'b10, 4'd3, 4'd3, 32'h11, 32'h22);
        checkOutput("r3.second.ready", 32'(seen_ready), 32'h2);
        checkOutput("r3.mid.bank", bank[3], 32'h11);
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
        checkOutput("r3.final.bank", bank[3], 32'h22);

        // Randomized traffic that honours the hold-until-accepted rule, with occasional drops and holds.
        cur_v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cur_a[i] = '0;
            cur_d[i] = '0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!cur_v[i] || exp_grant[i]) begin
                    cur_v[i] = ($urandom_range(0, 3) != 0);
                    cur_a[i] = 4'($urandom_range(0, 15));
                    cur_d[i] = $urandom;
                end else if ($urandom_range(0, 15) == 0) begin
                    cur_v[i] = 1'b0;
                end
            end
            applyStimulus(($urandom_range(0, 7) == 0), cur_v, cur_a[0], cur_a[1], cur_d[0], cur_d[1]);
            checkAgainstModel($sformatf("rand%0d", n));
        end
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
        checkAgainstModel("drain");
        for (int r = 0; r < NREG; r++) begin
            if (m_written[r]) checkOutput($sformatf("bank.R%0d", r), bank[r], m_bank[r]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
